// File: rtl/ex_cond_stage_pkg.sv
// ex_cond_stage_pkg
//   Shared processor definitions used by the execute-stage condition logic:
//   condition-code encodings (instr[31:28]), NZCV bit positions inside the
//   4-bit flags word, and the layout of the E-stage control register together
//   with its bubble value.
package ex_cond_stage_pkg;

  // Condition field encodings, instr[31:28].
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Bit positions of the architectural flags inside {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Number of independently writable flag groups: {N,Z} and {C,V}.
  localparam int FLAG_HALVES = 2;

  // Control word carried from D into E.
  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic       no_write;
    logic [3:0] alu_control;
    logic [1:0] flag_w;
    cond_e      cond;
  } ex_ctrl_t;

  // A bubble has every enable cleared and an always-true condition, so it
  // can never write registers, memory, PC or flags.
  localparam ex_ctrl_t EX_BUBBLE = '{
    pcs:         1'b0,
    reg_w:       1'b0,
    mem_w:       1'b0,
    mem_to_reg:  1'b0,
    branch:      1'b0,
    alu_src:     1'b0,
    no_write:    1'b0,
    alu_control: 4'd0,
    flag_w:      2'b00,
    cond:        COND_AL
  };

endpackage

// File: rtl/ex_cond_stage_cond_check.sv
// cond_check
//   Purely combinational evaluation of an instruction's condition field
//   against the architectural flags.
//   Ports:
//     CondE   in  4  condition field of the instruction in E
//     Flags   in  4  architectural flags {N,Z,C,V}
//     CondExE out 1  1 when the instruction is allowed to take effect
module cond_check
  import ex_cond_stage_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] Flags,
  output logic       CondExE
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;

  assign n_flag = Flags[FLAG_N];
  assign z_flag = Flags[FLAG_Z];
  assign c_flag = Flags[FLAG_C];
  assign v_flag = Flags[FLAG_V];

  always_comb begin
    CondExE = 1'b0;
    case (cond_e'(CondE))
      COND_EQ: CondExE = z_flag;
      COND_NE: CondExE = ~z_flag;
      COND_CS: CondExE = c_flag;
      COND_CC: CondExE = ~c_flag;
      COND_MI: CondExE = n_flag;
      COND_PL: CondExE = ~n_flag;
      COND_VS: CondExE = v_flag;
      COND_VC: CondExE = ~v_flag;
      COND_HI: CondExE = c_flag & ~z_flag;
      COND_LS: CondExE = ~c_flag | z_flag;
      COND_GE: CondExE = (n_flag == v_flag);
      COND_LT: CondExE = (n_flag != v_flag);
      COND_GT: CondExE = ~z_flag & (n_flag == v_flag);
      COND_LE: CondExE = z_flag | (n_flag != v_flag);
      COND_AL: CondExE = 1'b1;
      COND_NV: CondExE = 1'b0;
      default: CondExE = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_cond_stage.sv
// ex_cond_stage
//   Execute-stage pipeline register plus conditional-execution logic.
//   D-stage controls are captured into the E register every rising edge
//   (hold on StallE, bubble on FlushE, FlushE wins). The instruction in E is
//   gated by its condition against the flags register, and may update the
//   {N,Z} and/or {C,V} halves of the flags at the end of its E cycle.
//   Ports:
//     clk, reset                    clock and asynchronous active-high reset
//     PCSD..NoWriteD, ALUControlD,
//     FlagWD, CondD                 D-stage controls and condition field
//     StallE, FlushE                hazard controls for the E register
//     ALUFlags                      {N,Z,C,V} from the ALU for the E instruction
//     PCSrcE, RegWriteE, MemWriteE,
//     BranchTakenE                  condition-gated write enables
//     MemtoRegE, ALUSrcE,
//     ALUControlE                   ungated pass-through controls
//     CondExE                       condition result for the E instruction
//     FlagsE                        architectural flags {N,Z,C,V}
module ex_cond_stage
  import ex_cond_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       PCSD,
  input  logic       RegWD,
  input  logic       MemWD,
  input  logic       MemtoRegD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic       NoWriteD,
  input  logic [3:0] ALUControlD,
  input  logic [1:0] FlagWD,
  input  logic [3:0] CondD,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic [3:0] ALUFlags,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       BranchTakenE,
  output logic       MemtoRegE,
  output logic       ALUSrcE,
  output logic       CondExE,
  output logic [3:0] ALUControlE,
  output logic [3:0] FlagsE
);

  ex_ctrl_t   d_ctrl;
  ex_ctrl_t   e_reg;
  ex_ctrl_t   e_next;
  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic [FLAG_HALVES-1:0] flag_half_we;
  logic       cond_ex;

  // Gather the D-stage controls into one control word.
  always_comb begin
    d_ctrl             = EX_BUBBLE;
    d_ctrl.pcs         = PCSD;
    d_ctrl.reg_w       = RegWD;
    d_ctrl.mem_w       = MemWD;
    d_ctrl.mem_to_reg  = MemtoRegD;
    d_ctrl.branch      = BranchD;
    d_ctrl.alu_src     = ALUSrcD;
    d_ctrl.no_write    = NoWriteD;
    d_ctrl.alu_control = ALUControlD;
    d_ctrl.flag_w      = FlagWD;
    d_ctrl.cond        = cond_e'(CondD);
  end

  always_comb begin
    e_next = d_ctrl;
    if (FlushE) begin
      e_next = EX_BUBBLE;
    end else if (StallE) begin
      e_next = e_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_reg <= EX_BUBBLE;
    end else begin
      e_reg <= e_next;
    end
  end

  cond_check u_cond_check (
    .CondE   (e_reg.cond),
    .Flags   (flags_reg),
    .CondExE (cond_ex)
  );

  // Each flag half is written only by an executing instruction that is
  // leaving E this cycle. While stalled the same instruction will be seen
  // again, so writing now would update the flags twice.
  genvar gi;
  generate
    for (gi = 0; gi < FLAG_HALVES; gi++) begin : g_flag_half
      assign flag_half_we[gi] = e_reg.flag_w[gi] & cond_ex & ~StallE;
      assign flags_next[2*gi +: 2] = flag_half_we[gi] ? ALUFlags[2*gi +: 2]
                                                      : flags_reg[2*gi +: 2];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg <= 4'b0000;
    end else begin
      flags_reg <= flags_next;
    end
  end

  assign CondExE      = cond_ex;
  assign RegWriteE    = e_reg.reg_w & cond_ex & ~e_reg.no_write;
  assign MemWriteE    = e_reg.mem_w & cond_ex;
  assign PCSrcE       = e_reg.pcs & cond_ex;
  assign BranchTakenE = e_reg.branch & cond_ex;
  assign MemtoRegE    = e_reg.mem_to_reg;
  assign ALUSrcE      = e_reg.alu_src;
  assign ALUControlE  = e_reg.alu_control;
  assign FlagsE       = flags_reg;

endmodule

// File: tb/tb_ex_cond_stage.sv
module tb_ex_cond_stage;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       mem2reg;
    logic       branch;
    logic       alusrc;
    logic       nowrite;
    logic [3:0] aluc;
    logic [1:0] flagw;
    logic [3:0] cond;
  } ctl_t;

  logic       clk;
  logic       reset;
  logic       PCSD, RegWD, MemWD, MemtoRegD, BranchD, ALUSrcD, NoWriteD;
  logic [3:0] ALUControlD;
  logic [1:0] FlagWD;
  logic [3:0] CondD;
  logic       StallE, FlushE;
  logic [3:0] ALUFlags;
  logic       PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE, ALUSrcE, CondExE;
  logic [3:0] ALUControlE;
  logic [3:0] FlagsE;

  ex_cond_stage dut (
    .clk          (clk),
    .reset        (reset),
    .PCSD         (PCSD),
    .RegWD        (RegWD),
    .MemWD        (MemWD),
    .MemtoRegD    (MemtoRegD),
    .BranchD      (BranchD),
    .ALUSrcD      (ALUSrcD),
    .NoWriteD     (NoWriteD),
    .ALUControlD  (ALUControlD),
    .FlagWD       (FlagWD),
    .CondD        (CondD),
    .StallE       (StallE),
    .FlushE       (FlushE),
    .ALUFlags     (ALUFlags),
    .PCSrcE       (PCSrcE),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .BranchTakenE (BranchTakenE),
    .MemtoRegE    (MemtoRegE),
    .ALUSrcE      (ALUSrcE),
    .CondExE      (CondExE),
    .ALUControlE  (ALUControlE),
    .FlagsE       (FlagsE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus for the next D instruction and hazard inputs.
  ctl_t       din;
  logic       stall_i;
  logic       flush_i;
  logic [3:0] aluflags_i;

  // Reference model: the instruction sitting in E and the architectural flags.
  ctl_t       m_e;
  logic [3:0] m_flags;

  int checks_total;
  int checks_passed;
  int txn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  // Architectural meaning of each condition mnemonic.
  function automatic logic holds(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'd0:  return z;                     // EQ
      4'd1:  return !z;                    // NE
      4'd2:  return c;                     // CS
      4'd3:  return !c;                    // CC
      4'd4:  return n;                     // MI
      4'd5:  return !n;                    // PL
      4'd6:  return v;                     // VS
      4'd7:  return !v;                    // VC
      4'd8:  return c && !z;               // HI
      4'd9:  return !c || z;               // LS
      4'd10: return n == v;                // GE
      4'd11: return n != v;                // LT
      4'd12: return !z && (n == v);        // GT
      4'd13: return z || (n != v);         // LE
      4'd14: return 1'b1;                  // AL
      default: return 1'b0;                // NV
    endcase
  endfunction

  function automatic ctl_t bubble();
    ctl_t b;
    b = '0;
    b.cond = 4'hE;
    return b;
  endfunction

  task automatic model_reset();
    m_e     = bubble();
    m_flags = 4'b0000;
  endtask

  // One rising edge worth of architectural behaviour.
  task automatic model_update();
    logic pass;
    pass = holds(m_e.cond, m_flags);
    if (!stall_i && pass) begin
      if (m_e.flagw[1]) m_flags[3:2] = aluflags_i[3:2];
      if (m_e.flagw[0]) m_flags[1:0] = aluflags_i[1:0];
    end
    if (flush_i)       m_e = bubble();
    else if (!stall_i) m_e = din;
  endtask

  task automatic check_outputs();
    logic ex;
    ex = holds(m_e.cond, m_flags);
    check("condex",  CondExE,      ex);
    check("regw",    RegWriteE,    m_e.regw && ex && !m_e.nowrite);
    check("memw",    MemWriteE,    m_e.memw && ex);
    check("pcsrc",   PCSrcE,       m_e.pcs && ex);
    check("btaken",  BranchTakenE, m_e.branch && ex);
    check("mem2reg", MemtoRegE,    m_e.mem2reg);
    check("alusrc",  ALUSrcE,      m_e.alusrc);
    check("aluctl",  ALUControlE,  m_e.aluc);
    check("flags",   FlagsE,       m_flags);
  endtask

  // Called just after a falling edge: drive, check, take one rising edge,
  // and return just after the following falling edge.
  task automatic step();
    PCSD        = din.pcs;
    RegWD       = din.regw;
    MemWD       = din.memw;
    MemtoRegD   = din.mem2reg;
    BranchD     = din.branch;
    ALUSrcD     = din.alusrc;
    NoWriteD    = din.nowrite;
    ALUControlD = din.aluc;
    FlagWD      = din.flagw;
    CondD       = din.cond;
    StallE      = stall_i;
    FlushE      = flush_i;
    ALUFlags    = aluflags_i;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    $display("txn %0d cond=%h flagw=%b stall=%0b flush=%0b alu=%b -> flags=%b",
             txn, din.cond, din.flagw, stall_i, flush_i, aluflags_i, m_flags);
    txn++;
    @(negedge clk);
  endtask

  task automatic nop();
    din        = bubble();
    stall_i    = 1'b0;
    flush_i    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    txn           = 0;
    reset         = 1'b1;
    nop();
    aluflags_i    = 4'b0000;
    PCSD = 0; RegWD = 0; MemWD = 0; MemtoRegD = 0; BranchD = 0; ALUSrcD = 0;
    NoWriteD = 0; ALUControlD = 0; FlagWD = 0; CondD = 0; StallE = 0; FlushE = 0;
    ALUFlags = 0;
    model_reset();

    // Reset state, sampled with reset still asserted.
    @(negedge clk);
    check("rst_regw",  RegWriteE,    1'b0);
    check("rst_memw",  MemWriteE,    1'b0);
    check("rst_pcsrc", PCSrcE,       1'b0);
    check("rst_btk",   BranchTakenE, 1'b0);
    check("rst_aluc",  ALUControlE,  4'd0);
    check("rst_flags", FlagsE,       4'b0000);
    check("rst_cond",  CondExE,      1'b1);
    reset = 1'b0;

    // CMP-like: flag setter that must not write a register.
    din = bubble(); din.flagw = 2'b11; din.nowrite = 1'b1; din.regw = 1'b1;
    aluflags_i = 4'b0110;
    step();
    check("cmp_regw", RegWriteE, 1'b0);
    nop(); aluflags_i = 4'b0110;
    step();
    check("cmp_flags", FlagsE, 4'b0110);

    // Conditional branch with Z=1.
    din = bubble(); din.branch = 1'b1; din.pcs = 1'b1; din.cond = 4'h0;
    aluflags_i = 4'b0000;
    step();
    check("beq_btk", BranchTakenE, 1'b1);
    check("beq_pcs", PCSrcE,       1'b1);
    din.cond = 4'h1;
    step();
    check("bne_btk", BranchTakenE, 1'b0);
    check("bne_pcs", PCSrcE,       1'b0);

    // Partial flag write, then an NV instruction that must not write flags.
    din = bubble(); din.flagw = 2'b11; aluflags_i = 4'b0000;
    step();
    din = bubble(); din.flagw = 2'b10; aluflags_i = 4'b1111;
    step();
    check("part_pre", FlagsE, 4'b1111);
    din = bubble(); din.flagw = 2'b11; din.cond = 4'hF; aluflags_i = 4'b0000;
    step();
    check("part_nz", FlagsE, 4'b0011);
    nop(); aluflags_i = 4'b1010;
    step();
    check("nv_hold", FlagsE, 4'b0011);

    // Stall for two cycles, then stall together with flush.
    din = bubble(); din.regw = 1'b1; din.flagw = 2'b11; din.aluc = 4'd5;
    aluflags_i = 4'b0101;
    step();
    check("stl_pre", RegWriteE, 1'b1);
    din = bubble(); din.memw = 1'b1; stall_i = 1'b1; aluflags_i = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stl_regw",  RegWriteE,   1'b1);
      check("stl_memw",  MemWriteE,   1'b0);
      check("stl_aluc",  ALUControlE, 4'd5);
      check("stl_flags", FlagsE,      4'b0011);
    end
    stall_i = 1'b0; aluflags_i = 4'b1000;
    step();
    check("stl_rel_flags", FlagsE,    4'b1000);
    check("stl_rel_memw",  MemWriteE, 1'b1);
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    check("sf_regw",  RegWriteE,    1'b0);
    check("sf_memw",  MemWriteE,    1'b0);
    check("sf_pcs",   PCSrcE,       1'b0);
    check("sf_btk",   BranchTakenE, 1'b0);
    check("sf_aluc",  ALUControlE,  4'd0);

    // SUBS setting Z, immediately followed by ADDEQ.
    nop();
    din.regw = 1'b1; din.flagw = 2'b11; aluflags_i = 4'b0000;
    step();
    din = bubble(); din.regw = 1'b1; din.cond = 4'h0; aluflags_i = 4'b0100;
    step();
    check("b2b_regw", RegWriteE, 1'b1);

    // Asynchronous reset between edges with a live instruction in E.
    din = bubble(); din.regw = 1'b1; din.flagw = 2'b11; aluflags_i = 4'b0000;
    step();
    din = bubble(); din.regw = 1'b1; aluflags_i = 4'b1010;
    step();
    check("ar_pre_regw",  RegWriteE, 1'b1);
    check("ar_pre_flags", FlagsE,    4'b1010);
    reset = 1'b1;
    #2;
    check("ar_regw",  RegWriteE, 1'b0);
    check("ar_flags", FlagsE,    4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    check("ar_hold_regw",  RegWriteE, 1'b0);
    check("ar_hold_flags", FlagsE,    4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      din        = ctl_t'($urandom);
      stall_i    = ($urandom_range(0, 7) == 0);
      flush_i    = ($urandom_range(0, 9) == 0);
      aluflags_i = 4'($urandom);
      step();
    end
    nop();
    step();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
